// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and FSM state encoding for tx and rx
package uart_pkg;

  localparam int BAUD_MAX_DEF = 5208;
  localparam int DATA_BIT     = 8;
  localparam int STOP_BIT     = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter 0..BAUD_MAX-1, tick on the last cycle of each bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_MAX = BAUD_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero while disabled so every frame starts with a fresh bit phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8-N-1 or 8-E-1 framing with valid/ready byte handshake
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_MAX = BAUD_MAX_DEF,
  parameter int PARI_BIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] data_in,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  uart_state_e         state, state_next;
  logic [DATA_BIT-1:0] shreg, shreg_next;
  logic [2:0]          bit_cnt, bit_cnt_next;
  logic                par, par_next;
  logic                tx_next, ready_next, done_next;
  logic                tick;
  logic                baud_en;

  assign baud_en = (state != IDLE);

  uart_baud_gen #(
    .BAUD_MAX(BAUD_MAX)
  ) u_baud_gen (
    .clk (clk),
    .rst (rst),
    .en  (baud_en),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      par      <= par_next;
      tx       <= tx_next;
      tx_ready <= ready_next;
      tx_done  <= done_next;
    end
  end

  // tx is registered from tx_next, which is the level of the bit the FSM is entering.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    par_next     = par;
    tx_next      = tx;
    ready_next   = tx_ready;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        if (tx_valid && tx_ready) begin
          state_next   = START;
          shreg_next   = data_in;
          bit_cnt_next = '0;
          par_next     = 1'b0;
          tx_next      = 1'b0;
          ready_next   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          tx_next    = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          // Parity accumulates over the latched bits as they shift out.
          par_next   = par ^ shreg[0];
          shreg_next = {1'b0, shreg[DATA_BIT-1:1]};
          if (bit_cnt == 3'(DATA_BIT - 1)) begin
            bit_cnt_next = '0;
            if (PARI_BIT != 0) begin
              state_next = PARITY;
              tx_next    = par ^ shreg[0];
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            tx_next      = shreg[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (bit_cnt == 3'(STOP_BIT - 1)) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            done_next    = 1'b1;
            ready_next   = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        ready_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx, with and without parity
module tb_uart_tx;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       rdy0, tx0, done0, rdy1, tx1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_MAX(BAUD), .PARI_BIT(0)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(v0), .data_in(d0),
    .tx_ready(rdy0), .tx(tx0), .tx_done(done0)
  );

  uart_tx #(.BAUD_MAX(BAUD), .PARI_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .data_in(d1),
    .tx_ready(rdy1), .tx(tx1), .tx_done(done1)
  );

  // Expected per-cycle {tx, tx_ready, tx_done}, starting the cycle after acceptance.
  logic [2:0] exp_q[$];
  logic [2:0] cap[0:1023];

  function automatic void model_frame(input logic [7:0] b, input bit with_par);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (with_par) bits.push_back(^b);
    bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < BAUD; c++) exp_q.push_back({bits[i], 1'b0, 1'b0});
    exp_q.push_back(3'b111);
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin v1 = v; d1 = d; end
    else     begin v0 = v; d0 = d; end
  endtask

  task automatic launch(input bit sel, input logic [7:0] b, input bit hold);
    exp_q.delete();
    @(negedge clk);
    set_in(sel, 1'b1, b);
    @(posedge clk);
    #1;
    if (!hold) set_in(sel, 1'b0, 8'($urandom));
  endtask

  task automatic capture(input bit sel, input int n, input bit scramble);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap[k] = sel ? {tx1, rdy1, done1} : {tx0, rdy0, done0};
      if (scramble) set_in(sel, (k < n - 20) ? 1'($urandom) : 1'b0, 8'($urandom));
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ({tx0, rdy0, done0, tx1, rdy1, done1} !== 6'b110_110) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b want 110110", k,
                 {tx0, rdy0, done0, tx1, rdy1, done1});
      end
    end
  endtask

  task automatic test_frame_55;
    launch(1'b0, 8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    capture(1'b0, exp_q.size(), 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (cap[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL frame_55 cyc %0d: got %b want %b", k, cap[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_frame_a3_parity;
    launch(1'b1, 8'hA3, 1'b0);
    model_frame(8'hA3, 1'b1);
    capture(1'b1, exp_q.size(), 1'b0);
    checks++;
    if (exp_q.size() != 177) begin
      errors++;
      $display("FAIL a3_length: got %0d want 177", exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (cap[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL frame_a3 cyc %0d: got %b want %b", k, cap[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    launch(1'b0, 8'h0F, 1'b1);
    set_in(1'b0, 1'b1, 8'hF0);
    model_frame(8'h0F, 1'b0);
    model_frame(8'hF0, 1'b0);
    capture(1'b0, exp_q.size(), 1'b0);
    set_in(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (cap[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", k, cap[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_data_change;
    for (int it = 0; it < 2; it++) begin
      bit         sel = it[0];
      logic [7:0] b   = 8'($urandom);
      launch(sel, b, 1'b0);
      model_frame(b, sel);
      capture(sel, exp_q.size(), 1'b1);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (cap[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL data_change byte %h cyc %0d: got %b want %b", b, k, cap[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      bit         sel = 1'($urandom);
      logic [7:0] b   = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      launch(sel, b, 1'b0);
      model_frame(b, sel);
      capture(sel, exp_q.size(), 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (cap[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL random byte %h par %0d cyc %0d: got %b want %b", b, sel, k, cap[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b   = 8'($urandom) & 8'hEF;
    logic [7:0] rec = 8'h00;
    int         cut = 5 * BAUD + 8;
    launch(1'b0, b, 1'b0);
    model_frame(b, 1'b0);
    capture(1'b0, cut, 1'b0);
    for (int k = 0; k < cut; k++) begin
      checks++;
      if (cap[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL pre_reset cyc %0d: got %b want %b", k, cap[k], exp_q[k]);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx0, rdy0, done0} !== 3'b110) begin
      errors++;
      $display("FAIL async_reset: got %b want 110", {tx0, rdy0, done0});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({tx0, rdy0, done0} !== 3'b110) begin
        errors++;
        $display("FAIL post_reset_idle cyc %0d: got %b want 110", k, {tx0, rdy0, done0});
      end
    end
    launch(1'b0, 8'h81, 1'b0);
    model_frame(8'h81, 1'b0);
    capture(1'b0, exp_q.size(), 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (cap[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL post_reset_81 cyc %0d: got %b want %b", k, cap[k], exp_q[k]);
      end
    end
    // Behavioural receiver: sample each bit at its centre.
    for (int i = 0; i < 8; i++) rec[i] = cap[(i + 1) * BAUD + BAUD / 2][2];
    checks++;
    if (cap[BAUD / 2][2] !== 1'b0 || cap[9 * BAUD + BAUD / 2][2] !== 1'b1 || rec !== 8'h81) begin
      errors++;
      $display("FAIL loopback: got %h start %b stop %b want 81 start 0 stop 1",
               rec, cap[BAUD / 2][2], cap[9 * BAUD + BAUD / 2][2]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, rdy0, done0, tx1, rdy1, done1} !== 6'b110_110) begin
      errors++;
      $display("FAIL in_reset: got %b want 110110", {tx0, rdy0, done0, tx1, rdy1, done1});
    end
    rst = 1'b0;
    test_reset();
    test_frame_55();
    test_frame_a3_parity();
    test_back_to_back();
    test_data_change();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_MAX, default 5208, meaning clk cycles per bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter PARI_BIT, default 0, meaning 0 = no parity, 1 = even parity bit after the data bits.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_valid  input  1  a byte is offered on data_in.
REQ-006 SHALL have port data_in  input  8  byte to transmit.
REQ-007 SHALL have port tx_ready  output  1  high when the block can accept a byte.
REQ-008 SHALL have port tx  output  1  serial line; idle level is 1.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse when the last stop-bit period ends.

Function
REQ-010 SHALL transmit frames in 8-N-1 format (8-E-1 when PARI_BIT=1): start bit 0, data[0] first through data[7], optional parity, then one stop bit 1.
REQ-011 SHALL hold each bit on tx for exactly BAUD_MAX clk cycles, using a counter that runs 0..BAUD_MAX-1 and produces a tick at BAUD_MAX-1.
REQ-012 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP with one-hot or binary encoding, and no other reachable states.
REQ-013 SHALL accept a byte only on a cycle where tx_valid && tx_ready, latch data_in into a shift register on that edge, and move from IDLE to START.
REQ-014 SHALL drive tx=0 from the cycle after acceptance, i.e. 1 cycle of latency from handshake to start-bit edge.
REQ-015 SHALL deassert tx_ready on the acceptance edge and keep it low until the frame completes.
REQ-016 SHALL ignore tx_valid and data_in changes while tx_ready=0.
REQ-017 SHALL move START->DATA on a tick, stay in DATA for 8 ticks (3-bit bit counter, shift right per tick), then go to PARITY if PARI_BIT=1, otherwise to STOP.
REQ-018 SHALL compute parity as the XOR of the latched byte (even parity), using the latched copy and not data_in.
REQ-019 SHALL move STOP->IDLE on the tick ending the stop bit, pulse tx_done for exactly that one cycle, and reassert tx_ready on the same edge.
REQ-020 SHALL, if tx_valid is held high across frame end, accept the next byte on the first cycle tx_ready=1, so the frames are separated by one idle-high cycle.
REQ-021 SHALL hold the baud counter at 0 while in IDLE and restart it from 0 on acceptance, with no phase carried over between frames.
REQ-022 SHALL drive tx from a register, with no combinational path from inputs to tx.
REQ-023 SHALL drive tx=1 in IDLE and STOP, and on any illegal state return to IDLE with tx=1.

Reset
REQ-024 SHALL, while rst=1, force tx=1, tx_ready=1, tx_done=0, state=IDLE, and baud counter, bit counter and shift register to 0.
REQ-025 SHALL abandon any frame in progress when reset is asserted mid-frame, with tx going high asynchronously, and SHALL resume at IDLE with no residual output after release.
REQ-026 SHALL accept no byte on the first clk edge after rst deasserts unless tx_valid=1 on that edge.

Structure
REQ-027 SHALL take BAUD_MAX default, DATA_BIT=8, STOP_BIT=1 and the state encoding from shared package uart_pkg, which the receiver also uses.
REQ-028 SHALL put the baud counter and tick in a sub-module uart_baud_gen (inputs: clk, rst, en; output: tick), reusable by the receiver.
REQ-029 SHALL be implementable in 120-400 lines of RTL, with no FIFO inside the block.

Verification (BAUD_MAX=16 for simulation)
REQ-030 Reset release, tx_valid=0 for 100 cycles -> tx=1, tx_ready=1, tx_done=0 throughout.
REQ-031 Send 0x55 with PARI_BIT=0 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles, 160 cycles total; tx_done pulses once at cycle 160 after the start edge.
REQ-032 Send 0xA3 with PARI_BIT=1 -> bits 0,1,1,0,0,0,1,0,1, parity 0, stop 1, 176 cycles.
REQ-033 Hold tx_valid=1 with 0x0F then 0xF0 -> two correct frames with one idle cycle between them, and 0xF0 not accepted before tx_done.
REQ-034 Change data_in mid-frame -> transmitted byte equals the latched value; tx_ready stays 0.
REQ-035 Assert rst during data bit 4 -> tx=1 immediately; after release, a new byte 0x81 is transmitted correctly; a loopback check through the receiver recovers 0x81.
